// File: rtl/cordic_multi_mode_if.sv
// TinyQV peripheral bus bundle: register address, write/read strobes,
// read data and acknowledge. The CPU side is the master.
interface cordic_multi_mode_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/cordic_multi_mode.sv
// Iterative CORDIC co-processor on the TinyQV peripheral bus.
// Rotation mode produces (x*cos - y*sin, y*cos + x*sin) scaled by the
// CORDIC gain; vectoring mode produces magnitude (scaled) and atan(y/x).
// One micro-rotation per clock, results rounded and saturated to WIDTH.
// GUARD must be at least 1.
module cordic_multi_mode #(
  parameter int WIDTH = 16,
  parameter int ITERS = 14,
  parameter int GUARD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         ui_in,
  output logic [7:0]         uo_out,
  cordic_multi_mode_if.slave bus,
  output logic               user_interrupt
);

  // Internal datapath: GUARD extra integer bits and GUARD extra fraction bits
  localparam int IW = WIDTH + 2 * GUARD;
  localparam int FB = WIDTH - 2 + GUARD;

  // The atan table is held with 24 fraction bits and re-aligned to FB
  localparam int          ATAN_SHR  = (FB < 24) ? 24 - FB : 0;
  localparam int          ATAN_SHL  = (FB > 24) ? FB - 24 : 0;
  localparam logic [63:0] ATAN_HALF = (64'd1 << ATAN_SHR) >> 1;

  localparam logic signed [IW:0] RND_HALF = (IW + 1)'(2 ** (GUARD - 1));
  localparam logic signed [IW:0] SAT_MAX  = (IW + 1)'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [IW:0] SAT_MIN  = -SAT_MAX - (IW + 1)'(1);

  // pi/2 in Q2.(WIDTH-2), derived from 2*atan(1) with 24 fraction bits
  localparam int                      HALF_PI_Q = (26353590 + (1 << (25 - WIDTH))) >> (26 - WIDTH);
  localparam logic signed [WIDTH-1:0] HALF_PI   = WIDTH'(HALF_PI_Q);

  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  localparam logic [5:0] A_X_IN   = 6'h00;
  localparam logic [5:0] A_Y_IN   = 6'h04;
  localparam logic [5:0] A_Z_IN   = 6'h08;
  localparam logic [5:0] A_CTRL   = 6'h0C;
  localparam logic [5:0] A_X_OUT  = 6'h10;
  localparam logic [5:0] A_Y_OUT  = 6'h14;
  localparam logic [5:0] A_Z_OUT  = 6'h18;
  localparam logic [5:0] A_STATUS = 6'h1C;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] x_in, y_in, z_in;
  logic signed [WIDTH-1:0] x_out, y_out, z_out;
  logic signed [WIDTH-1:0] x_fin, y_fin, z_fin;
  logic signed [IW-1:0]    x_acc, y_acc, z_acc;
  logic signed [IW-1:0]    x_sh, y_sh, atan_i;
  logic [4:0]              iter;
  logic                    mode, irq_en, run_mode;
  logic                    done, overrun, range_err;

  logic        wr_en, rd_en, start_req;
  logic        load, step, finish, busy;
  logic        rot_neg, range_hit;
  logic        rd_ack;
  logic [31:0] rd_val;
  logic        unused_bits;

  // atan(2^-idx) with 24 fraction bits, rounded to the datapath fraction
  function automatic logic signed [IW-1:0] atan_lut(input logic [4:0] idx);
    logic [63:0] raw;
    case (idx)
      5'd0:    raw = 64'd13176795;
      5'd1:    raw = 64'd7778716;
      5'd2:    raw = 64'd4110060;
      5'd3:    raw = 64'd2086331;
      5'd4:    raw = 64'd1047214;
      5'd5:    raw = 64'd524117;
      5'd6:    raw = 64'd262123;
      5'd7:    raw = 64'd131069;
      5'd8:    raw = 64'd65536;
      5'd9:    raw = 64'd32768;
      5'd10:   raw = 64'd16384;
      5'd11:   raw = 64'd8192;
      5'd12:   raw = 64'd4096;
      5'd13:   raw = 64'd2048;
      5'd14:   raw = 64'd1024;
      5'd15:   raw = 64'd512;
      5'd16:   raw = 64'd256;
      5'd17:   raw = 64'd128;
      5'd18:   raw = 64'd64;
      5'd19:   raw = 64'd32;
      5'd20:   raw = 64'd16;
      5'd21:   raw = 64'd8;
      5'd22:   raw = 64'd4;
      5'd23:   raw = 64'd2;
      default: raw = 64'd0;
    endcase
    raw = ((raw + ATAN_HALF) >> ATAN_SHR) << ATAN_SHL;
    return $signed(raw[IW-1:0]);
  endfunction

  // Drop the guard fraction bits with round-half-up, then clamp to WIDTH
  function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [IW-1:0] v);
    logic signed [IW:0] rnd;
    rnd = $signed({v[IW-1], v}) + RND_HALF;
    rnd = rnd >>> GUARD;
    if (rnd > SAT_MAX) return $signed(SAT_MAX[WIDTH-1:0]);
    if (rnd < SAT_MIN) return $signed(SAT_MIN[WIDTH-1:0]);
    return $signed(rnd[WIDTH-1:0]);
  endfunction

  // Operand in Q2.(WIDTH-2) to the guarded internal format
  function automatic logic signed [IW-1:0] widen(input logic signed [WIDTH-1:0] v);
    return $signed({{GUARD{v[WIDTH-1]}}, v, {GUARD{1'b0}}});
  endfunction

  function automatic logic [31:0] sext32(input logic signed [WIDTH-1:0] v);
    return {{(32 - WIDTH){v[WIDTH-1]}}, v};
  endfunction

  assign wr_en     = (bus.data_write_n != 2'b11);
  assign rd_en     = (bus.data_read_n != 2'b11);
  assign start_req = wr_en && (bus.address == A_CTRL) && bus.data_in[0];

  // Range check uses the MODE bit carried by the starting CTRL write
  assign range_hit = bus.data_in[1] ? x_in[WIDTH-1]
                                    : ((z_in > HALF_PI) || (z_in < -HALF_PI));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: ITERS cycles of RUN, then one finishing cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req) state_nxt = S_RUN;
      S_RUN:   if (iter == LAST_ITER) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: datapath strobes and the BUSY indication
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    busy   = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        load = start_req;
      end
      S_RUN:   step   = 1'b1;
      S_FIN:   finish = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  // Micro-rotation terms; sign(0) is treated as positive
  assign x_sh    = x_acc >>> iter;
  assign y_sh    = y_acc >>> iter;
  assign atan_i  = atan_lut(iter);
  assign rot_neg = run_mode ? ~y_acc[IW-1] : z_acc[IW-1];

  assign x_fin = round_sat(x_acc);
  assign y_fin = round_sat(y_acc);
  assign z_fin = round_sat(z_acc);

  // CORDIC accumulators and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_acc    <= '0;
      y_acc    <= '0;
      z_acc    <= '0;
      iter     <= '0;
      run_mode <= 1'b0;
    end else if (load) begin
      x_acc    <= widen(x_in);
      y_acc    <= widen(y_in);
      z_acc    <= widen(z_in);
      iter     <= '0;
      run_mode <= bus.data_in[1];
    end else if (step) begin
      if (rot_neg) begin
        x_acc <= x_acc + y_sh;
        y_acc <= y_acc - x_sh;
        z_acc <= z_acc + atan_i;
      end else begin
        x_acc <= x_acc - y_sh;
        y_acc <= y_acc + x_sh;
        z_acc <= z_acc - atan_i;
      end
      iter <= iter + 5'd1;
    end
  end

  // Result registers, written in the finishing cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else if (finish) begin
      x_out <= x_fin;
      y_out <= y_fin;
      z_out <= z_fin;
    end
  end

  // Operand and control registers; writes land even while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_in   <= '0;
      y_in   <= '0;
      z_in   <= '0;
      mode   <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_en) begin
      case (bus.address)
        A_X_IN: x_in <= bus.data_in[WIDTH-1:0];
        A_Y_IN: y_in <= bus.data_in[WIDTH-1:0];
        A_Z_IN: z_in <= bus.data_in[WIDTH-1:0];
        A_CTRL: begin
          mode   <= bus.data_in[1];
          irq_en <= bus.data_in[2];
        end
        default: ;
      endcase
    end
  end

  // Sticky status flags; a completion outranks a same-cycle clear of DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      overrun   <= 1'b0;
      range_err <= 1'b0;
    end else if (load) begin
      done      <= 1'b0;
      overrun   <= 1'b0;
      range_err <= range_hit;
    end else begin
      if (wr_en && (bus.address == A_STATUS)) begin
        if (bus.data_in[1]) done      <= 1'b0;
        if (bus.data_in[2]) overrun   <= 1'b0;
        if (bus.data_in[3]) range_err <= 1'b0;
      end
      if (start_req && busy) overrun <= 1'b1;
      if (finish)            done    <= 1'b1;
    end
  end

  // Read mux; result reads stall through RUN and are served from the
  // rounding logic during the finishing cycle
  always_comb begin
    rd_ack = 1'b1;
    rd_val = 32'd0;
    case (bus.address)
      A_X_IN:   rd_val = sext32(x_in);
      A_Y_IN:   rd_val = sext32(y_in);
      A_Z_IN:   rd_val = sext32(z_in);
      A_CTRL:   rd_val = {29'd0, irq_en, mode, 1'b0};
      A_X_OUT: begin
        rd_ack = (state != S_RUN);
        rd_val = sext32((state == S_FIN) ? x_fin : x_out);
      end
      A_Y_OUT: begin
        rd_ack = (state != S_RUN);
        rd_val = sext32((state == S_FIN) ? y_fin : y_out);
      end
      A_Z_OUT: begin
        rd_ack = (state != S_RUN);
        rd_val = sext32((state == S_FIN) ? z_fin : z_out);
      end
      A_STATUS: rd_val = {28'd0, range_err, overrun, done, busy};
      default:  rd_val = 32'd0;
    endcase
  end

  assign bus.data_ready  = wr_en | (rd_en & rd_ack);
  assign bus.data_out    = (rd_en && rd_ack) ? rd_val : 32'd0;
  assign user_interrupt  = done & irq_en;
  assign uo_out          = 8'd0;
  assign unused_bits     = ^{ui_in, bus.data_in[31:WIDTH]};

endmodule

// File: tb/tb_cordic_multi_mode.sv
// Directed bench for cordic_multi_mode: a 16-bit/14-iteration instance and
// a 20-bit/18-iteration instance share one bus stimulus; sel picks which
// instance's read data is observed.
`timescale 1ns/1ps
module tb_cordic_multi_mode;

  localparam logic [5:0] A_X_IN   = 6'h00;
  localparam logic [5:0] A_Y_IN   = 6'h04;
  localparam logic [5:0] A_Z_IN   = 6'h08;
  localparam logic [5:0] A_CTRL   = 6'h0C;
  localparam logic [5:0] A_X_OUT  = 6'h10;
  localparam logic [5:0] A_Y_OUT  = 6'h14;
  localparam logic [5:0] A_Z_OUT  = 6'h18;
  localparam logic [5:0] A_STATUS = 6'h1C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo16, uo20;
  logic        irq16, irq20;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  wr_n, rd_n;
  logic        sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_multi_mode_if bus16();
  cordic_multi_mode_if bus20();

  assign bus16.address      = address;
  assign bus16.data_in      = data_in;
  assign bus16.data_write_n = wr_n;
  assign bus16.data_read_n  = rd_n;
  assign bus20.address      = address;
  assign bus20.data_in      = data_in;
  assign bus20.data_write_n = wr_n;
  assign bus20.data_read_n  = rd_n;

  wire        rdy  = sel ? bus20.data_ready : bus16.data_ready;
  wire [31:0] rdat = sel ? bus20.data_out   : bus16.data_out;

  cordic_multi_mode #(.WIDTH(16), .ITERS(14), .GUARD(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo16),
    .bus(bus16), .user_interrupt(irq16)
  );

  cordic_multi_mode #(.WIDTH(20), .ITERS(18), .GUARD(2)) dut20 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo20),
    .bus(bus20), .user_interrupt(irq20)
  );

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    wr_n    = 2'b00;
    @(posedge clk);
    #1;
    wr_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output int stalls);
    @(negedge clk);
    address = a;
    rd_n    = 2'b00;
    stalls  = 0;
    #1;
    while (!rdy && stalls < 60) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    d = rdat;
    @(posedge clk);
    #1;
    rd_n = 2'b11;
  endtask

  task automatic wait_irq(input logic which, output int n);
    n = 0;
    while (!(which ? irq20 : irq16) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic load_rot16(input logic [31:0] z);
    bus_write(A_X_IN, 32'd9949);
    bus_write(A_Y_IN, 32'd0);
    bus_write(A_Z_IN, z);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int st;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq16 !== 1'b0 || uo16 !== 8'd0) begin
      failures++;
      $display("FAIL reset_outs irq=%b uo=%h expected irq=0 uo=00", irq16, uo16);
    end
    checks++;
    if (bus16.data_ready !== 1'b0 || bus16.data_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus ready=%b out=%h expected 0/0", bus16.data_ready, bus16.data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(A_STATUS, d, st);
    checks++;
    if (d !== 32'd0 || st !== 0) begin
      failures++;
      $display("FAIL reset_status got=%h stalls=%0d expected 0/0", d, st);
    end
    bus_read(A_X_OUT, d, st);
    checks++;
    if (d !== 32'd0 || st !== 0) begin
      failures++;
      $display("FAIL reset_xout got=%h stalls=%0d expected 0/0", d, st);
    end
    bus_write(A_CTRL, 32'h6);
    bus_read(A_CTRL, d, st);
    checks++;
    if (d !== 32'h6) begin
      failures++;
      $display("FAIL ctrl_readback got=%h expected 00000006", d);
    end
    bus_write(6'h20, 32'hFFFF_FFFF);
    bus_read(6'h20, d, st);
    checks++;
    if (d !== 32'd0 || st !== 0) begin
      failures++;
      $display("FAIL unmapped_read got=%h stalls=%0d expected 0/0", d, st);
    end
    bus_write(A_CTRL, 32'h0);
  endtask

  task automatic test_rotation();
    logic [31:0] d;
    int st, n, v;
    load_rot16(32'd8579);
    bus_write(A_CTRL, 32'h5);
    wait_irq(1'b0, n);
    checks++;
    if (n !== 15) begin
      failures++;
      $display("FAIL rot_latency got=%0d expected 15", n);
    end
    bus_read(A_STATUS, d, st);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL rot_status got=%h expected 00000002", d);
    end
    bus_read(A_X_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < 14181 || v > 14197) begin
      failures++;
      $display("FAIL rot_x got=%0d expected 14189+-8", v);
    end
    bus_read(A_Y_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < 8184 || v > 8200) begin
      failures++;
      $display("FAIL rot_y got=%0d expected 8192+-8", v);
    end
    bus_read(A_Z_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < -8 || v > 8) begin
      failures++;
      $display("FAIL rot_z got=%0d expected 0+-8", v);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (irq16 !== 1'b1) begin
      failures++;
      $display("FAIL irq_hold got=%b expected 1", irq16);
    end
    bus_write(A_STATUS, 32'h2);
    checks++;
    if (irq16 !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear got=%b expected 0", irq16);
    end
  endtask

  task automatic test_vectoring();
    logic [31:0] d;
    int st, n, v;
    bus_write(A_X_IN, 32'd8192);
    bus_write(A_Y_IN, 32'd8192);
    bus_write(A_Z_IN, 32'd0);
    bus_write(A_CTRL, 32'h3);
    n = 0;
    d = 32'd0;
    while (d[1] !== 1'b1 && n < 40) begin
      bus_read(A_STATUS, d, st);
      n++;
    end
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL vec_status got=%h expected 00000002", d);
    end
    checks++;
    if (irq16 !== 1'b0) begin
      failures++;
      $display("FAIL vec_irq_masked got=%b expected 0", irq16);
    end
    bus_read(A_CTRL, d, st);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL vec_ctrl got=%h expected 00000002", d);
    end
    bus_read(A_Z_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < 12860 || v > 12876) begin
      failures++;
      $display("FAIL vec_z got=%0d expected 12868+-8", v);
    end
    bus_read(A_X_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < 19071 || v > 19087) begin
      failures++;
      $display("FAIL vec_x got=%0d expected 19079+-8", v);
    end
    bus_read(A_Y_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < -8 || v > 8) begin
      failures++;
      $display("FAIL vec_y got=%0d expected 0+-8", v);
    end
  endtask

  task automatic test_blocking_read();
    logic [31:0] d;
    int st, n, v;
    load_rot16(32'd8579);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_X_OUT, d, st);
    v = $signed(d);
    checks++;
    if (st !== 14) begin
      failures++;
      $display("FAIL block_stalls got=%0d expected 14", st);
    end
    checks++;
    if (v < 14181 || v > 14197) begin
      failures++;
      $display("FAIL block_value got=%0d expected 14189+-8", v);
    end
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STATUS, d, st);
    checks++;
    if (d[0] !== 1'b1 || st !== 0) begin
      failures++;
      $display("FAIL busy_read got=%h stalls=%0d expected busy=1 stalls=0", d, st);
    end
    n = 0;
    while (d[1] !== 1'b1 && n < 40) begin
      bus_read(A_STATUS, d, st);
      n++;
    end
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL block_done got=%h expected 00000002", d);
    end
  endtask

  task automatic test_overrun_range();
    logic [31:0] d;
    int st, n;
    load_rot16(32'hFFFF_9A70);
    bus_write(A_CTRL, 32'h5);
    repeat (2) @(posedge clk);
    bus_write(A_CTRL, 32'h5);
    wait_irq(1'b0, n);
    checks++;
    if (n !== 12) begin
      failures++;
      $display("FAIL overrun_latency got=%0d expected 12 after second start", n);
    end
    bus_read(A_STATUS, d, st);
    checks++;
    if (d !== 32'hE) begin
      failures++;
      $display("FAIL overrun_status got=%h expected 0000000e", d);
    end
    bus_write(A_STATUS, 32'hE);
    bus_read(A_STATUS, d, st);
    checks++;
    if (d !== 32'h0 || irq16 !== 1'b0) begin
      failures++;
      $display("FAIL status_clear got=%h irq=%b expected 0/0", d, irq16);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int st, n, v;
    load_rot16(32'd8579);
    bus_write(A_CTRL, 32'h5);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (irq16 !== 1'b0 || uo16 !== 8'd0 || bus16.data_ready !== 1'b0 || bus16.data_out !== 32'd0) begin
      failures++;
      $display("FAIL midreset_outs irq=%b uo=%h rdy=%b out=%h expected all 0",
               irq16, uo16, bus16.data_ready, bus16.data_out);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    bus_read(A_STATUS, d, st);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL midreset_status got=%h expected 00000000", d);
    end
    bus_read(A_X_OUT, d, st);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL midreset_xout got=%h expected 00000000", d);
    end
    bus_read(A_X_IN, d, st);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL midreset_xin got=%h expected 00000000", d);
    end
    load_rot16(32'd8579);
    bus_write(A_CTRL, 32'h5);
    wait_irq(1'b0, n);
    checks++;
    if (n !== 15) begin
      failures++;
      $display("FAIL restart_latency got=%0d expected 15", n);
    end
    bus_read(A_Y_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < 8184 || v > 8200) begin
      failures++;
      $display("FAIL restart_y got=%0d expected 8192+-8", v);
    end
  endtask

  task automatic test_width20();
    logic [31:0] d;
    int st, n, v;
    sel = 1'b1;
    repeat (30) @(posedge clk);
    bus_write(A_X_IN, 32'd159189);
    bus_write(A_Y_IN, 32'd0);
    bus_write(A_Z_IN, 32'd137258);
    bus_write(A_CTRL, 32'h5);
    wait_irq(1'b1, n);
    checks++;
    if (n !== 19) begin
      failures++;
      $display("FAIL w20_latency got=%0d expected 19", n);
    end
    bus_read(A_STATUS, d, st);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL w20_status got=%h expected 00000002", d);
    end
    bus_read(A_X_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < 227007 || v > 227039) begin
      failures++;
      $display("FAIL w20_x got=%0d expected 227023+-16", v);
    end
    bus_read(A_Y_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < 131056 || v > 131088) begin
      failures++;
      $display("FAIL w20_y got=%0d expected 131072+-16", v);
    end
    bus_read(A_Z_OUT, d, st);
    v = $signed(d);
    checks++;
    if (v < -16 || v > 16) begin
      failures++;
      $display("FAIL w20_z got=%0d expected 0+-16", v);
    end
    sel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ui_in   = 8'hA5;
    address = 6'h00;
    data_in = 32'd0;
    wr_n    = 2'b11;
    rd_n    = 2'b11;
    sel     = 1'b0;
    rst_n   = 1'b0;
    test_reset();
    test_rotation();
    test_vectoring();
    test_blocking_read();
    test_overrun_range();
    test_reset_mid();
    test_width20();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
